// File: rtl/micro_run_ctrl_if.sv
// Host/debug and core-side signal bundle for micro_run_ctrl.
// slave = the sequencer, master = the host plus micro core.
interface micro_run_ctrl_if #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
);
  logic             cmd_start;
  logic             cmd_halt;
  logic             cmd_step;
  logic             cmd_resume;
  logic             bp_en;
  logic [PC_W-1:0]  bp_addr;
  logic [PC_W-1:0]  pc;
  logic [CNT_W-1:0] max_cycles;
  logic             cpu_reset;
  logic             cpu_en;
  logic [2:0]       state;
  logic [CNT_W-1:0] cycles;
  logic [1:0]       halt_cause;
  logic             done;

  modport slave (
    input  cmd_start, cmd_halt, cmd_step, cmd_resume,
    input  bp_en, bp_addr, pc, max_cycles,
    output cpu_reset, cpu_en, state, cycles,
    output halt_cause, done
  );

  modport master (
    output cmd_start, cmd_halt, cmd_step, cmd_resume,
    output bp_en, bp_addr, pc, max_cycles,
    input  cpu_reset, cpu_en, state, cycles,
    input  halt_cause, done
  );
endinterface

// File: rtl/micro_run_ctrl.sv
// Run/halt/step sequencer for the 8-bit micro: drives core reset
// and per-cycle execute enable, with breakpoint and cycle budget.
module micro_run_ctrl #(
  parameter int PC_W       = 8,
  parameter int CNT_W      = 16,
  parameter int RST_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  micro_run_ctrl_if.slave   bus
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RST    = 3'd1,
    RUN    = 3'd2,
    STEP   = 3'd3,
    HALTED = 3'd4
  } st_t;

  st_t              st_q, st_n;
  logic [RC_W-1:0]  rst_cnt;
  logic [CNT_W-1:0] cycles_q;
  logic [1:0]       cause_q, cause_n;
  logic             done_q;
  logic             cpu_rst_q;
  logic             bp_skip, skip_set;
  logic             en;
  logic             bp_hit, lim_hit, halt_entry;

  assign bp_hit  = bus.bp_en && (bus.pc == bus.bp_addr) && !bp_skip;
  assign lim_hit = (bus.max_cycles != '0) && (cycles_q == bus.max_cycles);

  always_comb begin
    st_n     = st_q;
    cause_n  = 2'd0;
    en       = 1'b0;
    skip_set = 1'b0;
    case (st_q)
      IDLE: begin
        if (bus.cmd_start) st_n = RST;
      end
      RST: begin
        if (rst_cnt == RC_W'(RST_CYCLES - 1)) st_n = RUN;
      end
      RUN: begin
        if (bus.cmd_start) begin
          st_n = RST;
        end else if (bus.cmd_halt) begin
          st_n    = HALTED;
          cause_n = 2'd1;
        end else if (bp_hit) begin
          st_n    = HALTED;
          cause_n = 2'd2;
        end else if (lim_hit) begin
          st_n    = HALTED;
          cause_n = 2'd3;
        end else begin
          en = 1'b1;
        end
      end
      STEP: begin
        en      = 1'b1;
        st_n    = HALTED;
        cause_n = 2'd0;
      end
      HALTED: begin
        if (bus.cmd_start) begin
          st_n = RST;
        end else if (bus.cmd_step) begin
          st_n     = STEP;
          skip_set = 1'b1;
        end else if (bus.cmd_resume) begin
          st_n     = RUN;
          skip_set = 1'b1;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  assign halt_entry = (st_n == HALTED) && (st_q != HALTED);

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q      <= IDLE;
      rst_cnt   <= '0;
      cycles_q  <= '0;
      cause_q   <= 2'd0;
      done_q    <= 1'b0;
      cpu_rst_q <= 1'b1;
      bp_skip   <= 1'b0;
    end else begin
      st_q      <= st_n;
      rst_cnt   <= (st_q == RST) ? rst_cnt + 1'b1 : '0;
      done_q    <= halt_entry;
      cpu_rst_q <= (st_n == IDLE) || (st_n == RST);
      if (halt_entry) cause_q <= cause_n;
      // saturate instead of wrapping so a long run never reads as short
      if (st_n == RST)
        cycles_q <= '0;
      else if (en && (cycles_q != '1))
        cycles_q <= cycles_q + 1'b1;
      if (skip_set)
        bp_skip <= 1'b1;
      else if (en)
        bp_skip <= 1'b0;
    end
  end

  assign bus.cpu_en     = en;
  assign bus.cpu_reset  = cpu_rst_q;
  assign bus.state      = st_q;
  assign bus.cycles     = cycles_q;
  assign bus.halt_cause = cause_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_micro_run_ctrl.sv
// Bench for micro_run_ctrl: directed scenarios plus a randomized
// run checked against a cycle-level model of the sequencing rules.
module tb_micro_run_ctrl;

  localparam int PC_W  = 8;
  localparam int CNT_W = 16;
  localparam int RSTC  = 2;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [PC_W-1:0] pc = '0;

  int checks = 0;
  int errors = 0;

  micro_run_ctrl_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  micro_run_ctrl #(
    .PC_W(PC_W), .CNT_W(CNT_W), .RST_CYCLES(RSTC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // stand-in micro core: pc advances one instruction per enabled cycle
  always @(posedge clk) begin
    if (bus.cpu_reset) pc <= '0;
    else if (bus.cpu_en) pc <= pc + 1'b1;
  end
  assign bus.pc = pc;

  // reference model: 0 idle, 1 reset, 2 run, 3 step, 4 halted
  int m_state = 0;
  int m_rst = 0;
  int m_cycles = 0;
  int m_cause = 0;
  bit m_done = 0;
  bit m_cpu_reset = 1;
  bit m_armed_skip = 0;
  bit m_en = 0;
  logic en_seen;
  logic [PC_W-1:0] pc_s;

  function automatic bit model_en();
    bit stop;
    if (m_state == 3) return 1'b1;
    if (m_state != 2) return 1'b0;
    stop = bus.cmd_start || bus.cmd_halt;
    stop |= bus.bp_en && (pc_s == bus.bp_addr) && !m_armed_skip;
    stop |= (bus.max_cycles != 0) && (m_cycles == int'(bus.max_cycles));
    return !stop;
  endfunction

  task automatic model_clock();
    int nxt;
    if (reset) begin
      m_state = 0; m_rst = 0; m_cycles = 0; m_cause = 0;
      m_done = 0; m_cpu_reset = 1; m_armed_skip = 0;
      return;
    end
    nxt = m_state;
    if (m_state == 0 && bus.cmd_start) nxt = 1;
    if (m_state == 1 && m_rst == RSTC - 1) nxt = 2;
    if (m_state == 3) begin nxt = 4; m_cause = 0; end
    if (m_state == 2) begin
      if (bus.cmd_start) nxt = 1;
      else if (!m_en) begin
        nxt = 4;
        if (bus.cmd_halt) m_cause = 1;
        else if (bus.bp_en && pc_s == bus.bp_addr && !m_armed_skip)
          m_cause = 2;
        else m_cause = 3;
      end
    end
    if (m_en) m_armed_skip = 0;
    if (m_state == 4) begin
      if (bus.cmd_start) nxt = 1;
      else if (bus.cmd_step) begin nxt = 3; m_armed_skip = 1; end
      else if (bus.cmd_resume) begin nxt = 2; m_armed_skip = 1; end
    end
    if (nxt == 1) m_cycles = 0;
    else if (m_en && m_cycles < SAT) m_cycles++;
    m_rst = (m_state == 1) ? m_rst + 1 : 0;
    m_done = (nxt == 4) && (m_state != 4);
    m_cpu_reset = (nxt == 0) || (nxt == 1);
    m_state = nxt;
  endtask

  task automatic tick();
    @(negedge clk);
    pc_s = pc;
    m_en = model_en();
    en_seen = bus.cpu_en;
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic clr_cmds();
    bus.cmd_start = 0; bus.cmd_halt = 0;
    bus.cmd_step = 0; bus.cmd_resume = 0;
  endtask

  task automatic do_reset();
    reset = 1; tick(); tick(); reset = 0;
  endtask

  task automatic wait_halted(input string nm);
    for (int i = 0; i < 200 && bus.state !== 3'd4; i++) tick();
    checks++;
    if (bus.state !== 3'd4) begin
      errors++;
      $display("FAIL %s timeout state=%0d want 4", nm, bus.state);
    end
  endtask

  task automatic test_reset();
    clr_cmds();
    bus.bp_en = 0; bus.bp_addr = '0; bus.max_cycles = '0;
    do_reset();
    tick();
    checks += 5;
    if (bus.state !== 3'd0) begin errors++;
      $display("FAIL rst_state got %0d want 0", bus.state); end
    if (bus.cpu_reset !== 1'b1) begin errors++;
      $display("FAIL rst_cpu_reset got %b want 1", bus.cpu_reset); end
    if (en_seen !== 1'b0) begin errors++;
      $display("FAIL rst_cpu_en got %b want 0", en_seen); end
    if (bus.cycles !== '0 || bus.done !== 1'b0) begin errors++;
      $display("FAIL rst_cycles_done got %0d/%b want 0/0",
               bus.cycles, bus.done); end
    if (bus.halt_cause !== 2'd0) begin errors++;
      $display("FAIL rst_cause got %0d want 0", bus.halt_cause); end
  endtask

  task automatic test_start_run();
    bus.cmd_halt = 1; tick(); bus.cmd_halt = 0;
    checks++;
    if (bus.state !== 3'd0) begin errors++;
      $display("FAIL idle_ignores got %0d want 0", bus.state); end
    bus.cmd_start = 1; tick(); bus.cmd_start = 0;
    for (int i = 0; i < RSTC; i++) begin
      checks++;
      if (bus.state !== 3'd1 || bus.cpu_reset !== 1'b1) begin errors++;
        $display("FAIL rst_hold[%0d] got st=%0d cr=%b want 1/1",
                 i, bus.state, bus.cpu_reset); end
      if (i < RSTC - 1) tick();
    end
    tick();
    checks++;
    if (bus.state !== 3'd2 || bus.cpu_reset !== 1'b0) begin errors++;
      $display("FAIL run_entry got st=%0d cr=%b want 2/0",
               bus.state, bus.cpu_reset); end
    for (int i = 1; i <= 6; i++) begin
      tick();
      checks++;
      if (en_seen !== 1'b1 || bus.cycles !== CNT_W'(i)) begin errors++;
        $display("FAIL run_count[%0d] got en=%b cyc=%0d want 1/%0d",
                 i, en_seen, bus.cycles, i); end
    end
  endtask

  task automatic test_breakpoint();
    do_reset();
    bus.bp_en = 1; bus.bp_addr = 8'd8;
    bus.cmd_start = 1; tick(); bus.cmd_start = 0;
    wait_halted("bp_halt");
    checks++;
    if (pc !== 8'd8 || bus.halt_cause !== 2'd2 || bus.done !== 1'b1
        || bus.cycles !== 16'd8) begin errors++;
      $display("FAIL bp_hit got pc=%0d cause=%0d done=%b cyc=%0d want 8/2/1/8",
               pc, bus.halt_cause, bus.done, bus.cycles); end
    tick();
    checks++;
    if (bus.done !== 1'b0 || pc !== 8'd8) begin errors++;
      $display("FAIL bp_hold got done=%b pc=%0d want 0/8", bus.done, pc); end
    bus.cmd_resume = 1; tick(); bus.cmd_resume = 0;
    tick();
    checks++;
    if (en_seen !== 1'b1 || pc !== 8'd9) begin errors++;
      $display("FAIL bp_resume got en=%b pc=%0d want 1/9", en_seen, pc); end
    tick();
    checks++;
    if (bus.state !== 3'd2 || pc !== 8'd10) begin errors++;
      $display("FAIL bp_rearm got st=%0d pc=%0d want 2/10", bus.state, pc); end
    bus.cmd_halt = 1; tick(); bus.cmd_halt = 0;
    checks++;
    if (bus.state !== 3'd4 || bus.halt_cause !== 2'd1) begin errors++;
      $display("FAIL host_halt got st=%0d cause=%0d want 4/1",
               bus.state, bus.halt_cause); end
  endtask

  task automatic test_step();
    logic [PC_W-1:0] pc0;
    logic [CNT_W-1:0] c0;
    int dones;
    pc0 = pc; c0 = bus.cycles; dones = 0;
    for (int i = 0; i < 3; i++) begin
      bus.cmd_step = 1; tick(); bus.cmd_step = 0;
      tick();
      if (en_seen === 1'b1 && bus.done === 1'b1 && bus.state === 3'd4)
        dones++;
      tick();
      if (bus.done === 1'b1) dones = dones + 10;
    end
    checks += 2;
    if (pc !== pc0 + 8'd3 || bus.cycles !== c0 + 16'd3) begin errors++;
      $display("FAIL step_adv got pc=%0d cyc=%0d want %0d/%0d",
               pc, bus.cycles, pc0 + 8'd3, c0 + 16'd3); end
    if (dones != 3 || bus.halt_cause !== 2'd0) begin errors++;
      $display("FAIL step_done got dones=%0d cause=%0d want 3/0",
               dones, bus.halt_cause); end
  endtask

  task automatic test_limit();
    do_reset();
    bus.bp_en = 0; bus.max_cycles = 16'd5;
    bus.cmd_start = 1; tick(); bus.cmd_start = 0;
    wait_halted("lim_halt");
    checks++;
    if (bus.cycles !== 16'd5 || bus.halt_cause !== 2'd3 || pc !== 8'd5)
    begin errors++;
      $display("FAIL limit got cyc=%0d cause=%0d pc=%0d want 5/3/5",
               bus.cycles, bus.halt_cause, pc); end
    bus.max_cycles = '0;
    bus.cmd_start = 1; tick(); bus.cmd_start = 0;
    for (int i = 0; i < 30; i++) tick();
    checks++;
    if (bus.state !== 3'd2 || bus.cycles !== CNT_W'(30 - RSTC))
    begin errors++;
      $display("FAIL unlimited got st=%0d cyc=%0d want 2/%0d",
               bus.state, bus.cycles, 30 - RSTC); end
    bus.cmd_halt = 1; tick(); bus.cmd_halt = 0;
    checks++;
    if (bus.halt_cause !== 2'd1) begin errors++;
      $display("FAIL unl_halt got %0d want 1", bus.halt_cause); end
  endtask

  task automatic test_priority();
    do_reset();
    bus.bp_en = 1; bus.bp_addr = 8'd3; bus.max_cycles = '0;
    bus.cmd_start = 1; tick(); bus.cmd_start = 0;
    for (int i = 0; i < 20 && bus.state !== 3'd2; i++) tick();
    for (int i = 0; i < 3; i++) tick();
    bus.cmd_halt = 1; tick(); bus.cmd_halt = 0;
    checks++;
    if (bus.state !== 3'd4 || bus.halt_cause !== 2'd1 || pc !== 8'd3)
    begin errors++;
      $display("FAIL halt_vs_bp got st=%0d cause=%0d pc=%0d want 4/1/3",
               bus.state, bus.halt_cause, pc); end
    bus.cmd_start = 1; bus.cmd_step = 1; tick(); clr_cmds();
    checks++;
    if (bus.state !== 3'd1) begin errors++;
      $display("FAIL start_vs_step got %0d want 1", bus.state); end
  endtask

  task automatic test_reset_mid();
    bus.bp_en = 0;
    for (int i = 0; i < 40 && bus.cycles !== 16'd7; i++) tick();
    reset = 1; tick(); reset = 0;
    checks++;
    if (bus.state !== 3'd0 || bus.cycles !== '0 ||
        bus.cpu_reset !== 1'b1 || bus.cpu_en !== 1'b0) begin errors++;
      $display("FAIL mid_reset got st=%0d cyc=%0d cr=%b en=%b want 0/0/1/0",
               bus.state, bus.cycles, bus.cpu_reset, bus.cpu_en); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      bus.cmd_start  = ($urandom_range(0, 39) == 0);
      bus.cmd_halt   = ($urandom_range(0, 14) == 0);
      bus.cmd_step   = ($urandom_range(0, 4) == 0);
      bus.cmd_resume = ($urandom_range(0, 6) == 0);
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 29) == 0) begin
        bus.bp_en = 1'($urandom_range(0, 1));
        bus.bp_addr = PC_W'($urandom_range(0, 12));
        bus.max_cycles = ($urandom_range(0, 2) == 0) ? '0 :
                         CNT_W'($urandom_range(1, 40));
      end
      tick();
      checks++;
      if (en_seen !== m_en || bus.state !== 3'(m_state) ||
          bus.cycles !== CNT_W'(m_cycles) ||
          bus.halt_cause !== 2'(m_cause) || bus.done !== m_done ||
          bus.cpu_reset !== m_cpu_reset) begin
        errors++;
        $display("FAIL rand[%0d] got en=%b st=%0d cyc=%0d hc=%0d dn=%b cr=%b want %b/%0d/%0d/%0d/%b/%b",
                 n, en_seen, bus.state, bus.cycles, bus.halt_cause,
                 bus.done, bus.cpu_reset, m_en, m_state, m_cycles,
                 m_cause, m_done, m_cpu_reset);
      end
    end
    reset = 0; clr_cmds();
  endtask

  initial begin
    test_reset();
    test_start_run();
    test_breakpoint();
    test_step();
    test_limit();
    test_priority();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
